// File: rtl/wb_pkg.sv
// Shared constants and the queue entry type for the write-back queue.
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 64;
   localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

   // One pending register-file write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rw;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// One forwarding lookup: finds the youngest pending write to addr_i among the
// queue entries (walked oldest to youngest from head_i) and the output
// register, which has the lowest priority. Address 31 never matches.
module wbq_match
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [REG_ADDR_W-1:0]    addr_i,
   input  wb_entry_t                entries_i [DEPTH],
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [$clog2(DEPTH)-1:0] head_i,
   input  logic                     out_vld_i,
   input  wb_entry_t                out_i,
   output logic                     hit_o,
   output logic [DATA_W-1:0]        data_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   // Later (younger) matches override earlier ones; output register goes first.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      if (addr_i != XZR) begin
         if (out_vld_i && (out_i.rw == addr_i)) begin
            hit_o  = 1'b1;
            data_o = out_i.data;
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (entries_i[idx].rw == addr_i)) begin
               hit_o  = 1'b1;
               data_o = entries_i[idx].data;
            end
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue in front of the register file write port.
// In-order circular FIFO accepting writes over valid/ready and draining one
// entry per cycle into a registered RW/BusW/RegWr output.
// Handshake: a request transfers on a rising edge when InValid & InReady;
// InReady depends only on Count. Writes to register 31 are accepted and dropped.
// Optional feature macro WBQ_BYPASS_EN enables RA/RB forwarding; without it
// HitA/HitB/FwdA/FwdB are tied to 0.
module writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         InValid,
   output logic                         InReady,
   input  logic [REG_ADDR_W-1:0]        InRW,
   input  logic [DATA_W-1:0]            InData,
   input  logic                         Hold,
   output logic [REG_ADDR_W-1:0]        RW,
   output logic [DATA_W-1:0]            BusW,
   output logic                         RegWr,
   input  logic [REG_ADDR_W-1:0]        RA,
   input  logic [REG_ADDR_W-1:0]        RB,
   output logic                         HitA,
   output logic                         HitB,
   output logic [DATA_W-1:0]            FwdA,
   output logic [DATA_W-1:0]            FwdB,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic                         Empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_entry_t             entries_q [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [REG_ADDR_W-1:0] rw_q, rw_d;
   logic [DATA_W-1:0]     busw_q, busw_d;
   logic                  regwr_q, regwr_d;
   logic                  push, pop;

   assign InReady = (count_q != CNT_W'(DEPTH));
   assign push    = InValid & InReady & (InRW != XZR);
   // Uses the registered count, so an entry pushed into an empty queue waits a cycle.
   assign pop     = (count_q != '0) & ~Hold;

   // Next-state for pointers, occupancy and the drain output register.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      rw_d    = rw_q;
      busw_d  = busw_q;
      regwr_d = 1'b0;
      if (push) tail_d = tail_q + 1'b1;
      if (pop) begin
         head_d  = head_q + 1'b1;
         rw_d    = entries_q[head_q].rw;
         busw_d  = entries_q[head_q].data;
         regwr_d = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state and output register; reset cancels any write in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rw_q    <= XZR;
         busw_q  <= '0;
         regwr_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         regwr_q <= regwr_d;
      end
   end

   // Entry storage; contents of unoccupied slots are never observed.
   always_ff @(posedge Clk) begin
      if (push) entries_q[tail_q] <= {InRW, InData};
   end

   assign RW    = rw_q;
   assign BusW  = busw_q;
   assign RegWr = regwr_q;
   assign Count = count_q;
   assign Empty = (count_q == '0) & ~regwr_q;

`ifdef WBQ_BYPASS_EN
   logic [DEPTH-1:0] valid_mask;
   logic [PTR_W-1:0] off;
   wb_entry_t        out_ent;

   assign out_ent = {rw_q, busw_q};

   // Slot i is occupied when its distance from head is below the count.
   always_comb begin
      valid_mask = '0;
      off        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off           = PTR_W'(i) - head_q;
         valid_mask[i] = (CNT_W'(off) < count_q);
      end
   end

   wbq_match #(.DEPTH(DEPTH)) u_match_a (
      .addr_i    (RA),
      .entries_i (entries_q),
      .valid_i   (valid_mask),
      .head_i    (head_q),
      .out_vld_i (regwr_q),
      .out_i     (out_ent),
      .hit_o     (HitA),
      .data_o    (FwdA)
   );

   wbq_match #(.DEPTH(DEPTH)) u_match_b (
      .addr_i    (RB),
      .entries_i (entries_q),
      .valid_i   (valid_mask),
      .head_i    (head_q),
      .out_vld_i (regwr_q),
      .out_i     (out_ent),
      .hit_o     (HitB),
      .data_o    (FwdB)
   );
`else
   logic unused_read_addr;
   assign unused_read_addr = ^{RA, RB};
   assign HitA = 1'b0;
   assign HitB = 1'b0;
   assign FwdA = '0;
   assign FwdB = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: inputs driven and outputs sampled
// on the falling edge; drained writes are checked against an expected queue.
module tb_writeback_queue;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRW;
   logic [63:0] InData;
   logic        Hold;
   logic [4:0]  RW;
   logic [63:0] BusW;
   logic        RegWr;
   logic [4:0]  RA, RB;
   logic        HitA, HitB;
   logic [63:0] FwdA, FwdB;
   logic [2:0]  Count;
   logic        Empty;

`ifdef WBQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int wr_snap;
   logic [68:0] exp_q[$];

   writeback_queue #(.DEPTH(4)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InRW(InRW), .InData(InData), .Hold(Hold), .RW(RW), .BusW(BusW),
      .RegWr(RegWr), .RA(RA), .RB(RB), .HitA(HitA), .HitB(HitB),
      .FwdA(FwdA), .FwdB(FwdB), .Count(Count), .Empty(Empty)
   );

   // clock / watchdog
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fwd_exp(input logic [63:0] v);
      return BYP ? v : 64'h0;
   endfunction

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         @(negedge Clk);
      end
   endtask

   // Drive one request from a falling edge until it is accepted.
   task automatic send(input logic [4:0] rw, input logic [63:0] d);
      bit done = 0;
      InValid = 1'b1;
      InRW    = rw;
      InData  = d;
      for (int n = 0; n < 20 && !done; n++) begin
         if (InReady) begin
            if (rw != 5'd31) exp_q.push_back({rw, d});
            done = 1;
         end
         cycle(1);
      end
      InValid = 1'b0;
      if (!done) check("send_timeout", 64'd0, 64'd1);
   endtask

   // scoreboard: every write pulse must match the oldest expected entry
   always @(negedge Clk) begin
      if (!Reset && RegWr) begin
         logic [68:0] e;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_write", {59'd0, RW}, 64'd99);
         end else begin
            e = exp_q.pop_front();
            check("drain_rw", {59'd0, RW}, {59'd0, e[68:64]});
            check("drain_data", BusW, e[63:0]);
         end
      end
   end

   initial begin
      Reset = 1'b1; InValid = 1'b0; InRW = '0; InData = '0; Hold = 1'b0;
      RA = 5'd0; RB = 5'd0;
      cycle(2);
      check("rst_count", {61'd0, Count}, 64'd0);
      check("rst_ready", {63'd0, InReady}, 64'd1);
      check("rst_empty", {63'd0, Empty}, 64'd1);
      check("rst_regwr", {63'd0, RegWr}, 64'd0);
      check("rst_rw", {59'd0, RW}, 64'd31);
      check("rst_busw", BusW, 64'd0);
      check("rst_hita", {63'd0, HitA}, 64'd0);
      check("rst_fwdb", FwdB, 64'd0);
      Reset = 1'b0;
      cycle(1);

      // single write: pulse two edges after acceptance
      RA = 5'd3;
      send(5'd3, 64'h12345678);
      check("lat_regwr_n1", {63'd0, RegWr}, 64'd0);
      check("lat_count", {61'd0, Count}, 64'd1);
      check("lat_fwd_next_cycle", FwdA, fwd_exp(64'h12345678));
      cycle(1);
      check("lat_regwr_n2", {63'd0, RegWr}, 64'd1);
      check("lat_rw", {59'd0, RW}, 64'd3);
      cycle(1);
      check("lat_pulse_one", {63'd0, RegWr}, 64'd0);
      check("lat_empty", {63'd0, Empty}, 64'd1);

      // XZR discard
      wr_snap = wr_cnt;
      send(5'd31, 64'hFFFF);
      check("xzr_ready", {63'd0, InReady}, 64'd1);
      check("xzr_count", {61'd0, Count}, 64'd0);
      cycle(3);
      check("xzr_no_write", 64'(wr_cnt), 64'(wr_snap));

      // fill and wrap
      Hold = 1'b1;
      for (int i = 1; i <= 4; i++) send(5'(i), 64'(i));
      check("fill_count", {61'd0, Count}, 64'd4);
      check("fill_ready", {63'd0, InReady}, 64'd0);
      InValid = 1'b1; InRW = 5'd5; InData = 64'd5;
      cycle(2);
      check("fill_stall_count", {61'd0, Count}, 64'd4);
      Hold = 1'b0;
      cycle(1);
      check("full_pop_no_admit", {61'd0, Count}, 64'd3);
      check("full_ready_rises", {63'd0, InReady}, 64'd1);
      exp_q.push_back({5'd5, 64'd5});
      cycle(1);
      InValid = 1'b0;
      check("push_pop_count", {61'd0, Count}, 64'd3);
      cycle(6);
      check("fill_drained", {63'd0, Empty}, 64'd1);

      // bypass priority
      Hold = 1'b1; RA = 5'd7; RB = 5'd7;
      send(5'd7, 64'hA);
      send(5'd7, 64'hB);
      check("byp_hita", {63'd0, HitA}, {63'd0, BYP});
      check("byp_fwda_young", FwdA, fwd_exp(64'hB));
      check("byp_fwdb_young", FwdB, fwd_exp(64'hB));
      Hold = 1'b0;
      cycle(1);
      Hold = 1'b1;
      check("byp_drain_a", {63'd0, RegWr}, 64'd1);
      check("byp_queue_over_outreg", FwdA, fwd_exp(64'hB));
      RA = 5'd31;
      #1;
      check("byp_xzr_hit", {63'd0, HitA}, 64'd0);
      check("byp_xzr_fwd", FwdA, 64'd0);
      RA = 5'd7;
      Hold = 1'b0;
      cycle(1);
      check("byp_outreg_hit", {63'd0, HitA}, {63'd0, BYP});
      check("byp_outreg_fwd", FwdA, fwd_exp(64'hB));
      cycle(1);
      check("byp_gone_hit", {63'd0, HitB}, 64'd0);

      // simultaneous push and pop with two queued
      Hold = 1'b1;
      send(5'd10, 64'h10);
      send(5'd11, 64'h11);
      check("sim_pre_count", {61'd0, Count}, 64'd2);
      Hold = 1'b0;
      InValid = 1'b1; InRW = 5'd12; InData = 64'h12;
      exp_q.push_back({5'd12, 64'h12});
      cycle(1);
      InValid = 1'b0;
      check("sim_count", {61'd0, Count}, 64'd2);
      check("sim_oldest", {59'd0, RW}, 64'd10);
      cycle(4);
      check("sim_empty", {63'd0, Empty}, 64'd1);

      // reset in the middle of a drain
      Hold = 1'b1;
      for (int i = 0; i < 3; i++) send(5'(20 + i), 64'($urandom_range(1, 1000)));
      Hold = 1'b0;
      cycle(1);
      check("mid_regwr_pre", {63'd0, RegWr}, 64'd1);
      #2 Reset = 1'b1;
      #1;
      check("mid_regwr_drop", {63'd0, RegWr}, 64'd0);
      check("mid_count", {61'd0, Count}, 64'd0);
      exp_q.delete();
      @(negedge Clk);
      Reset = 1'b0;
      wr_snap = wr_cnt;
      cycle(4);
      check("mid_after_count", {61'd0, Count}, 64'd0);
      check("mid_after_rw", {59'd0, RW}, 64'd31);
      check("mid_no_writes", 64'(wr_cnt), 64'(wr_snap));

      check("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-back buffer that sits directly upstream of the 64-bit, 32-entry `RegisterFile` and is the only driver of its write port (`RW`, `BusW`, `RegWr`). It accepts result writes from the execute/memory stages over a valid/ready handshake and holds up to `DEPTH` of them in order. It drains one entry per cycle into the register file. Optionally, it forwards pending values to the decode stage so that reads of `BusA`/`BusB` never see stale data.

## Interface
- `DEPTH`, default 4: queue entries; a power of two, at least 2.
- `Clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `InValid` input, 1 bit: a write request is present.
- `InReady` output, 1 bit: the queue can accept a request this cycle.
- `InRW` input, 5 bits: destination register of the request.
- `InData` input, 64 bits: write data of the request.
- `Hold` input, 1 bit: suspends draining while high.
- `RW` output, 5 bits: register-file write address.
- `BusW` output, 64 bits: register-file write data.
- `RegWr` output, 1 bit: register-file write enable.
- `RA` input, 5 bits: decode read address A, the same value presented to `RegisterFile`.
- `RB` input, 5 bits: decode read address B, the same value presented to `RegisterFile`.
- `HitA` output, 1 bit: a pending write to `RA` exists.
- `HitB` output, 1 bit: a pending write to `RB` exists.
- `FwdA` output, 64 bits: youngest pending data for `RA`.
- `FwdB` output, 64 bits: youngest pending data for `RB`.
- `Count` output, `$clog2(DEPTH+1)` bits: occupied queue entries.
- `Empty` output, 1 bit: high when `Count` is 0 and `RegWr` is 0.

## Operation
- **Handshake.** A request is accepted on a rising edge when `InValid & InReady`.
  - `InReady = (Count != DEPTH)`. It is a function of `Count` only and never depends on `InValid`.
  - An accepted request with `InRW == 31` (XZR) completes the handshake but is discarded: it is not enqueued and `Count` is unchanged.
- **Queue.** The queue is a circular FIFO with head and tail pointers of `log2(DEPTH)` bits. Pointers wrap from `DEPTH-1` to 0.
- **Drain.**
  - On each rising edge with `Count > 0` and `!Hold`, the head entry is popped into the output register: `RW`/`BusW` load the entry and `RegWr` is set to 1.
  - Otherwise `RegWr` is set to 0, and `RW`/`BusW` hold their last values.
- **Simultaneous push and pop.** `Count` is unchanged. A request pushed into an empty queue is not popped on the same edge.
- **Full queue.** At `Count == DEPTH`, `InReady` is 0. A pop on the same edge does not admit a request; `InReady` rises on the following cycle.
- **Hold.** Draining stops while `Hold` is high. Requests keep being accepted until the queue is full.
- **Bypass.** Applies only when the `_EN` macro is defined.
  - Candidates for the `RA` match are every valid queue entry plus the output register while `RegWr` is 1. The output register is included because `RegisterFile` commits on the falling edge, so a read in that cycle still returns the old value.
  - Priority: the youngest queue entry wins, and the output register has the lowest priority.
  - `HitA` = any match. `FwdA` = the winning data, or 0 if there is no match.
  - `RA == 31` always gives `HitA = 0` and `FwdA = 0`.
  - `RB` is handled identically, producing `HitB`/`FwdB`.
  - This logic is combinational from `RA`/`RB` and the registered state.
- **Reset values.** On `Reset` (asynchronous, effective at any time):
  - `Count` = 0, both pointers = 0, `RegWr` = 0, `RW` = 31, `BusW` = 0.
  - `InReady` = 1, `Empty` = 1, `HitA` = `HitB` = 0, `FwdA` = `FwdB` = 0.
  - Pending entries are discarded. A `Reset` in the middle of a drain cancels the write in progress: `RegWr` drops immediately.

## Timing
- **Latency.** A request accepted at edge N into an empty queue, with `Hold` low, drives `RegWr = 1` during cycle N+1 to N+2. `RegisterFile` commits it on the falling edge in that cycle.
- **Write pulses.** `RegWr` is high for exactly one cycle per drained entry.
- **Throughput.** Back-to-back drains give one write per cycle.
- **Forwarding.** Forwarding outputs are valid in the same cycle as `RA`/`RB`. They include an entry in the cycle immediately after it is accepted.

## Configuration
- **`WBQ_BYPASS_EN` defined:** the match logic and the `HitA`/`HitB`/`FwdA`/`FwdB` behaviour described above.
- **`WBQ_BYPASS_EN` not defined:** the match logic is not compiled. The four ports remain, tied to 0, so the port list is identical in both builds.

## Structure
- **Package `wb_pkg`.**
  - Constants: `REG_ADDR_W = 5`, `DATA_W = 64`, `XZR = 5'd31`.
  - Typedef: `wb_entry_t`, a packed struct of `{rw, data}`.
- **Sub-module `wbq_match`.** One address lookup against the entry array, the valid mask, the age order and the output register, producing hit and data. It is instantiated twice, once for A and once for B.

## Test plan
- **Reset, then single write.** Push `InRW = 3`, `InData = 64'h12345678`. Expect `RegWr` high for one cycle, two edges after acceptance, with `RW = 3` and `BusW = 64'h12345678`. After this, `RegisterFile` `BusA` with `RA = 3` reads `64'h12345678`.
- **XZR discard.** Push `InRW = 31`, `InData = 64'hFFFF`. Expect `InReady` = 1, `Count` to stay 0, and no `RegWr` pulse.
- **Fill and wrap.** With `Hold = 1`, push `X1..X4 = 1..4`. Expect `Count = 4` and `InReady = 0`; a fifth push of `X5` is stalled. Release `Hold`. Expect writes in order 1, 2, 3, 4, then 5, with the pointers wrapped.
- **Bypass priority (`WBQ_BYPASS_EN`).** With `Hold = 1`, push `X7 = 64'hA` and then `X7 = 64'hB`, with `RA = 7`. Expect `HitA = 1` and `FwdA = 64'hB`. After the first entry drains, `FwdA` is still `64'hB`. With `RA = 31`, expect `HitA = 0`.
- **Simultaneous push and pop.** With `Count = 2`, push one request while draining. Expect `Count` to stay 2 and the drained entry to be the oldest.
- **Reset mid-drain.** With three entries queued, assert `Reset` mid-cycle while `RegWr = 1`. Expect `RegWr = 0` immediately, and after release `Count = 0`, `RW = 31` and no further writes.
